// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
package uart_pkg;

  // Smallest usable divisor: the mid-bit load of (baud>>1)-1 needs room.
  localparam int BAUD_MIN          = 4;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte handshake between the UART receiver and its consumer (RX FIFO / regs).
interface uart_rx_core_if #(
  parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  // Receiver side: produces bytes and status pulses.
  modport master (
    output rx_data, rx_valid, rx_frame_err, rx_overrun,
    input  rx_ready
  );

  // Consumer side: accepts bytes.
  modport slave (
    input  rx_data, rx_valid, rx_frame_err, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter that marks UART sample points; expire is high at zero.
module uart_rx_bit_timer #(
  parameter int BAUDRATE_CONFIG_BITWIDTH = 17
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                load,
  input  logic [BAUDRATE_CONFIG_BITWIDTH-1:0] load_val,
  output logic                                expire
);

  logic [BAUDRATE_CONFIG_BITWIDTH-1:0] count;

  // Count down to zero and park there until the next load.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1-style framing, mid-bit sampling, valid/ready byte output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUDRATE_CONFIG_BITWIDTH = 17,
  parameter int DATA_BITS                = DEFAULT_DATA_BITS
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [BAUDRATE_CONFIG_BITWIDTH-1:0] baud,
  input  logic                                rx_in,
  output logic                                rx_busy,
  uart_rx_core_if.master                      rx
);

  localparam int W  = BAUDRATE_CONFIG_BITWIDTH;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic [W-1:0]  BAUD_FLOOR = W'(BAUD_MIN);

  logic          rx_m;       // first synchroniser stage
  logic          rx_s;       // synchronised line
  logic          rx_p;       // previous rx_s, for edge detection
  logic          start_edge;

  rx_state_t            state;
  logic [W-1:0]         baud_l;
  logic [W-1:0]         baud_clamped;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 busy_q;

  logic         tmr_load;
  logic [W-1:0] tmr_val;
  logic         expire;

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign start_edge   = rx_p & ~rx_s;
  assign baud_clamped = (baud < BAUD_FLOOR) ? BAUD_FLOOR : baud;

  // Choose when and with what the bit timer is (re)loaded.
  // NOTE: defaults first so no path leaves an output unassigned (no latch).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = baud_l - 1'b1;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          tmr_load = 1'b1;
          tmr_val  = (baud_clamped >> 1) - 1'b1;
        end
      end
      START, DATA: tmr_load = expire;
      default: tmr_load = 1'b0;
    endcase
  end

  uart_rx_bit_timer #(
    .BAUDRATE_CONFIG_BITWIDTH(W)
  ) u_bit_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // Frame FSM with registered byte, handshake and status outputs.
  // NOTE: the shift register is reset too; it is a handful of flops, not a RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      baud_l  <= BAUD_FLOOR;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            baud_l <= baud_clamped;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (expire) begin
            if (rx_s) begin
              // Line back high at mid start bit: treat as a glitch.
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end

        DATA: begin
          if (expire) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        STOP: begin
          if (expire) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (!rx_s) begin
              ferr_q <= 1'b1;
            end else if (!valid_q || rx.rx_ready) begin
              data_q  <= shift;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = ferr_q;
  assign rx.rx_overrun   = ovr_q;
  assign rx_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames,
// compared every cycle against an event-level model of the receiver.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic [16:0] baud;
  logic        rx_in;
  logic        rx_busy;

  uart_rx_core_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_core #(
    .BAUDRATE_CONFIG_BITWIDTH(17),
    .DATA_BITS(8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .baud    (baud),
    .rx_in   (rx_in),
    .rx_busy (rx_busy),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit mon_en      = 1'b0;
  bit rnd_ready   = 1'b0;

  // One frame (or glitch) as seen from the line: when the receiver becomes
  // busy, when it reaches its decision point, and what it should decide.
  typedef struct {
    int         start_c;
    int         done_c;
    logic [7:0] d;
    bit         stop;
    bit         glitch;
  } ev_t;

  ev_t        evq[$];
  bit         m_valid;
  logic [7:0] m_data;
  bit         e_ferr, e_ovr, e_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp_baud(input int b);
    return (b < 4) ? 4 : b;
  endfunction

  // Reference model: at each edge, resolve a finished frame or the handshake.
  always @(posedge clk) begin
    bit   hit, ld, clr;
    ev_t  ev;
    cyc++;
    if (rstn) begin
      e_ferr = 1'b0;
      e_ovr  = 1'b0;
      ld     = 1'b0;
      clr    = m_valid && rx_if.rx_ready;
      hit    = (evq.size() > 0) && (evq[0].done_c == cyc);
      if (hit) begin
        ev = evq.pop_front();
        if (!ev.glitch) begin
          if (!ev.stop)                       e_ferr = 1'b1;
          else if (!m_valid || rx_if.rx_ready) ld    = 1'b1;
          else                                e_ovr  = 1'b1;
          if (ld) m_data = ev.d;
        end
      end
      if (ld)       m_valid = 1'b1;
      else if (clr) m_valid = 1'b0;
      e_busy = (evq.size() > 0) && (cyc >= evq[0].start_c) && (cyc < evq[0].done_c);
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      check("rx_valid", 32'(rx_if.rx_valid), 32'(m_valid));
      if (m_valid) check("rx_data", 32'(rx_if.rx_data), 32'(m_data));
      check("rx_frame_err", 32'(rx_if.rx_frame_err), 32'(e_ferr));
      check("rx_overrun", 32'(rx_if.rx_overrun), 32'(e_ovr));
      check("rx_busy", 32'(rx_busy), 32'(e_busy));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) rx_if.rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) tick();
  endtask

  // Drive one frame at the current baud setting. abort_at>0 stops half-way
  // through that bit slot; mid_baud>0 reprograms baud during data bit 4.
  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int abort_at = 0, input int mid_baud = 0);
    int   b, t0;
    logic bits [10];
    ev_t  ev;
    int   b_cfg;
    b_cfg = int'(baud);
    b  = clamp_baud(b_cfg);
    t0 = cyc + 1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = stop;
    ev.start_c = t0 + 2;
    ev.done_c  = t0 + 2 + b / 2 + 9 * b;
    ev.d       = d;
    ev.stop    = stop;
    ev.glitch  = 1'b0;
    evq.push_back(ev);
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      if (mid_baud > 0 && i == 5) baud = 17'(mid_baud);
      if (abort_at > 0 && i == abort_at) begin
        repeat (b / 2) tick();
        return;
      end
      repeat (b) tick();
    end
    if (mid_baud > 0) baud = 17'(b_cfg);
  endtask

  // Low pulse shorter than half a bit: must be rejected at the start sample.
  task automatic send_glitch(input int len);
    int  b, t0;
    ev_t ev;
    b  = clamp_baud(int'(baud));
    t0 = cyc + 1;
    ev.start_c = t0 + 2;
    ev.done_c  = t0 + 2 + b / 2;
    ev.d       = 8'h00;
    ev.stop    = 1'b1;
    ev.glitch  = 1'b1;
    evq.push_back(ev);
    rx_in = 1'b0;
    repeat (len) tick();
    idle(b + 2);
  endtask

  initial begin
    int b;
    bit st;
    rstn = 1'b0;
    rx_in = 1'b1;
    baud = 17'd16;
    rx_if.rx_ready = 1'b1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_if.rx_data), 32'd0);
    check("reset rx_frame_err", 32'(rx_if.rx_frame_err), 32'd0);
    check("reset rx_overrun", 32'(rx_if.rx_overrun), 32'd0);
    check("reset rx_busy", 32'(rx_busy), 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;
    idle(4);

    // Plain frame, consumer always ready.
    send_frame(8'hA5, 1'b1);
    idle(6);

    // Start-bit glitch of 4 cycles at baud 16.
    send_glitch(4);

    // Framing error, then the line stays low: no retrigger.
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (48) tick();
    idle(6);

    // Overrun: second byte arrives while the first is still pending.
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    rx_if.rx_ready = 1'b1;
    idle(4);

    // Divisor below the minimum, back-to-back frames.
    baud = 17'd2;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(6);

    // Reset in the middle of data bit 3 while a byte is pending.
    baud = 17'd16;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, 4);
    #1 rstn = 1'b0;
    evq.delete();
    m_valid = 1'b0; m_data = 8'h00;
    e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    #1;
    check("async reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("async reset rx_data", 32'(rx_if.rx_data), 32'd0);
    check("async reset rx_busy", 32'(rx_busy), 32'd0);
    rx_in = 1'b1;
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(4);
    // Baud reprogrammed mid-frame must not disturb the frame in flight.
    send_frame(8'h5A, 1'b1, 0, 32);
    idle(6);

    // Random frames, divisors, stop bits, gaps and consumer readiness.
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b    = int'($urandom_range(2, 24));
      baud = 17'(b);
      st   = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom), st);
      idle(st ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5)));
    end
    rnd_ready = 1'b0;
    rx_if.rx_ready = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver. It is the receive-side counterpart of the baud-clocked transmit path.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each bit at mid-period using the shared per-bit baud divisor.
- Presents received bytes on a valid/ready handshake, with framing-error and overrun flags.
- Sits between the pad-level rx line and the RX FIFO/register block, clocked by the system clock.

Parameters:
BAUDRATE_CONFIG_BITWIDTH, 17, width of baud divisor (clock cycles per bit)
DATA_BITS, 8, data bits per frame; fixed format 1 start, DATA_BITS data LSB-first, 1 stop, no parity

Ports:
clk  input  1  system clock; single clock domain
rstn  input  1  asynchronous active-low reset
baud  input  BAUDRATE_CONFIG_BITWIDTH  clock cycles per bit; values below 4 are treated as 4
rx_in  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
rx_valid  output  1  byte available; held until accepted
rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready
rx_frame_err  output  1  1-cycle pulse: stop bit sampled low
rx_overrun  output  1  1-cycle pulse: frame completed while previous byte not accepted
rx_busy  output  1  high in every state except IDLE

Behaviour:
Interface (already decided): one clock, clk; reset rstn is asynchronous, active-low.

Reset values:
- rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.
- State=IDLE.
- Synchroniser flops and edge-detect flop reset to 1 (line-idle level).

Input conditioning:
- rx_in passes through a 2-flop synchroniser, giving rx_s.
- A previous-value flop gives rx_p.
- Start edge = (rx_p==1 && rx_s==0), evaluated only in IDLE.
- A line held low never retriggers; a new edge is required.

Baud latch:
- At the start edge, baud_l = max(baud,4) is captured.
- Changes to baud mid-frame are ignored.

Bit timer:
- Down-counter, width BAUDRATE_CONFIG_BITWIDTH; expire when count==0.
- At the start edge (cycle E), load (baud_l>>1)-1.
- On each expiry, reload baud_l-1.
- Sample points, relative to E:
  - start bit: E+(baud_l>>1)
  - data bit k (0..DATA_BITS-1): E+(baud_l>>1)+(k+1)*baud_l
  - stop bit: E+(baud_l>>1)+(DATA_BITS+1)*baud_l

FSM (uart_pkg::rx_state_t):
- IDLE -> START on start edge.
- START, at expiry:
  - rx_s==1: false start (glitch) -> IDLE, no flags.
  - otherwise -> DATA, bit index=0.
- DATA, at expiry: shift rx_s into shift register MSB, so the first-received bit lands in LSB.
  - On bit index==DATA_BITS-1 -> STOP; otherwise increment bit index.
- STOP, at expiry -> IDLE. The next start edge may be detected on the following cycle. Outcome by case:
  - rx_s==0: rx_frame_err pulses the next cycle. Byte discarded; rx_valid and rx_data unchanged.
  - rx_s==1 and (rx_valid==0, or rx_ready==1 this cycle): rx_data<=shift register, rx_valid<=1 next cycle.
  - rx_s==1 and rx_valid==1 and rx_ready==0: rx_overrun pulses next cycle. New byte dropped; old byte retained.

Handshake:
- rx_valid clears the cycle after rx_valid&&rx_ready, unless a new byte loads that same cycle; then it stays 1 with the new data.
- Latency: rx_valid rises at E+(baud_l>>1)+(DATA_BITS+1)*baud_l+1.
- Pin-to-E delay is 3 cycles (2 synchroniser stages + edge register).

Reset mid-frame: immediately returns to IDLE, clears all outputs, discards any partial byte.

Decomposition:
- Package uart_pkg: rx_state_t enum (IDLE, START, DATA, STOP), localparam BAUD_MIN=4, default DATA_BITS. Shared with the TX side.
- Sub-module uart_rx_bit_timer (ports: clk, rstn, load, load_val, expire), instantiated once.
- Synchroniser and FSM stay inline.

Test Plan:
1. baud=16, frame 0xA5, rx_ready=1 -> rx_valid 1 cycle with rx_data=0xA5 at E+153; frame_err=0, overrun=0.
2. baud=16, rx_in low for 4 cycles then high -> START aborts at E+8, returns to IDLE; no rx_valid, no flags; rx_busy high E+1..E+8.
3. baud=16, frame 0x3C with stop bit=0 -> rx_frame_err single pulse at E+153; rx_valid stays 0; line held low afterwards produces no new frame until a fresh falling edge.
4. rx_ready=0, frames 0x11 then 0x22 -> rx_valid=1 with 0x11; rx_overrun pulse at end of second frame; rx_data still 0x11. Raising rx_ready clears rx_valid next cycle.
5. baud=2 (clamped to 4), back-to-back frames 0x00, 0xFF, 0x81 with rx_ready=1 -> all three received correctly; each rx_valid at E+39 relative to its own edge.
6. rstn asserted during DATA bit 3 of frame 0x5A -> outputs 0 immediately. After release, next full frame 0x5A is received correctly. A baud change mid-frame (16->32) does not alter timing of the frame in progress.
